// File: rtl/dcache_port_if.sv
// dcache_port_if: ld_* (MEM stage), st_*/flush (store buffer), cache_* (data cache), mem_stall/drain_empty status; master = arbiter side
interface dcache_port_if;
  logic        ld_req;
  logic [31:0] ld_addr;
  logic [2:0]  ld_funct3;
  logic        ld_done;
  logic [31:0] ld_rdata;
  logic        mem_stall;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [2:0]  st_funct3;
  logic        st_ready;
  logic        flush;
  logic        cache_req;
  logic        cache_we;
  logic [31:0] cache_addr;
  logic [31:0] cache_wdata;
  logic [2:0]  cache_funct3;
  logic        cache_done;
  logic [31:0] cache_rdata;
  logic        drain_empty;
  modport master (
    input  ld_req, ld_addr, ld_funct3, st_valid, st_addr, st_data, st_funct3, flush, cache_done, cache_rdata,
    output ld_done, ld_rdata, mem_stall, st_ready, cache_req, cache_we, cache_addr, cache_wdata, cache_funct3, drain_empty
  );
  modport slave (
    output ld_req, ld_addr, ld_funct3, st_valid, st_addr, st_data, st_funct3, flush, cache_done, cache_rdata,
    input  ld_done, ld_rdata, mem_stall, st_ready, cache_req, cache_we, cache_addr, cache_wdata, cache_funct3, drain_empty
  );
endinterface

// File: rtl/dcache_port_arbiter.sv
// dcache_port_arbiter: shares the dcache port (p.cache_*) between MEM loads (p.ld_*, p.mem_stall) and a drain queue of committed stores (p.st_*, p.flush, p.drain_empty); clk, sync active-high reset
module dcache_port_arbiter #(
  parameter int DRAIN_Q_DEPTH = 2,
  parameter int STARVE_LIMIT  = 4
) (
  input logic          clk,
  input logic          reset,
  dcache_port_if.master p
);
  localparam int AW = $clog2(DRAIN_Q_DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [AW:0]   FULL  = (AW + 1)'(DRAIN_Q_DEPTH);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);
  typedef enum logic [1:0] {IDLE, BUSY_LD, BUSY_ST} state_t;
  state_t state_q, state_d;
  logic [31:0] q_addr_q [DRAIN_Q_DEPTH];
  logic [31:0] q_data_q [DRAIN_Q_DEPTH];
  logic [2:0]  q_f3_q   [DRAIN_Q_DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, off;
  logic [AW:0] count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;
  logic kill_q, kill_d, req_q, req_d, we_q, we_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [2:0] f3_q, f3_d;
  logic enq, conflict, force_st, issue_st, issue_ld, done;
  assign enq = p.st_valid && p.st_ready;
  assign force_st = count_q == FULL || starve_q >= LIMIT || conflict;
  assign issue_st = state_q == IDLE && count_q != '0 && (force_st || !p.ld_req);
  assign issue_ld = state_q == IDLE && !issue_st && p.ld_req && !p.flush;
  assign done = state_q != IDLE && p.cache_done;
  assign p.st_ready = count_q < FULL;
  assign p.ld_done = state_q == BUSY_LD && p.cache_done && !kill_q && !p.flush;
  assign p.ld_rdata = p.cache_rdata;
  assign p.mem_stall = p.ld_req && !p.ld_done;
  assign p.drain_empty = count_q == '0 && state_q != BUSY_ST;
  assign p.cache_req = req_q;
  assign p.cache_we = we_q;
  assign p.cache_addr = addr_q;
  assign p.cache_wdata = wdata_q;
  assign p.cache_funct3 = f3_q;
  // only entries between rd_ptr and rd_ptr+count are live; word-granular match
  always_comb begin
    conflict = 1'b0;
    off = '0;
    for (int i = 0; i < DRAIN_Q_DEPTH; i++) begin
      off = AW'(i) - rd_ptr_q;
      conflict = conflict | ({1'b0, off} < count_q && q_addr_q[i][31:2] == p.ld_addr[31:2]);
    end
    conflict = conflict & p.ld_req;
  end
  always_comb begin
    state_d = state_q;
    req_d = req_q;
    we_d = we_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    f3_d = f3_q;
    rd_ptr_d = issue_st ? rd_ptr_q + AW'(1) : rd_ptr_q;
    wr_ptr_d = enq ? wr_ptr_q + AW'(1) : wr_ptr_q;
    count_d = count_q + (AW + 1)'(enq) - (AW + 1)'(issue_st);
    starve_d = issue_st ? '0 : (issue_ld && count_q != '0 && starve_q < LIMIT) ? starve_q + SW'(1) : starve_q;
    kill_d = state_q == BUSY_LD && !p.cache_done && (kill_q || p.flush);
    if (issue_st) begin
      state_d = BUSY_ST;
      req_d = 1'b1;
      we_d = 1'b1;
      addr_d = q_addr_q[rd_ptr_q];
      wdata_d = q_data_q[rd_ptr_q];
      f3_d = q_f3_q[rd_ptr_q];
    end else if (issue_ld) begin
      state_d = BUSY_LD;
      req_d = 1'b1;
      we_d = 1'b0;
      addr_d = p.ld_addr;
      wdata_d = '0;
      f3_d = p.ld_funct3;
    end else if (done) begin
      state_d = IDLE;
      req_d = 1'b0;
      we_d = 1'b0;
      addr_d = '0;
      wdata_d = '0;
      f3_d = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q <= '0;
      starve_q <= '0;
      kill_q <= 1'b0;
      req_q <= 1'b0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      f3_q <= '0;
    end else begin
      state_q <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q <= count_d;
      starve_q <= starve_d;
      kill_q <= kill_d;
      req_q <= req_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      f3_q <= f3_d;
    end
  end
  always_ff @(posedge clk) begin
    if (enq && !reset) begin
      q_addr_q[wr_ptr_q] <= p.st_addr;
      q_data_q[wr_ptr_q] <= p.st_data;
      q_f3_q[wr_ptr_q] <= p.st_funct3;
    end
  end
endmodule

// File: tb/tb_dcache_port_arbiter.sv
// tb_dcache_port_arbiter: table vectors plus hand sequences against a cache responder and a request scoreboard
module tb_dcache_port_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  dcache_port_if cif();
  dcache_port_arbiter #(.DRAIN_Q_DEPTH(2), .STARVE_LIMIT(4)) dut (.clk(clk), .reset(reset), .p(cif));
  typedef struct packed {logic we; logic [31:0] addr; logic [31:0] wdata; logic [2:0] f3;} txn_t;
  typedef struct {logic is_st; logic [31:0] addr; logic [31:0] data; logic [2:0] f3; logic [31:0] exp_rdata;} vec_t;
  txn_t exp_q[$];
  txn_t t;
  vec_t vecs[6];
  int checks = 0, passed = 0, cyc = 0, lat = 1, rcnt = 0;
  int n_lddone = 0, n_stdone = 0, last_done_cyc = 0, last_gap = 0;
  logic prev_req = 1'b0, stray_done = 1'b0;
  logic [31:0] last_rdata = '0, exp_ld_addr = '0;
  function automatic logic [31:0] rd_model(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask
  task automatic to_fail(input string name);
    checks++;
    $display("FAIL %s: timed out waiting on the DUT", name);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  always @(posedge clk) begin
    #2;
    cyc++;
    cif.cache_done = stray_done;
    cif.cache_rdata = '0;
    if (reset || !cif.cache_req) rcnt = 0;
    else begin
      rcnt++;
      if (rcnt == lat + 1) begin
        cif.cache_done = 1'b1;
        cif.cache_rdata = rd_model(cif.cache_addr);
        rcnt = 0;
      end
    end
  end
  always @(negedge clk) begin
    if (reset) prev_req = 1'b0;
    else begin
      if (cif.cache_req && !prev_req) begin
        last_gap = cyc - last_done_cyc;
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_req: got request we=%b addr %h, required none", cif.cache_we, cif.cache_addr);
        end else begin
          t = exp_q.pop_front();
          if (!t.we) exp_ld_addr = t.addr;
          check("req_we", 32'(cif.cache_we), 32'(t.we));
          check("req_addr", cif.cache_addr, t.addr);
          check("req_wdata", cif.cache_wdata, t.wdata);
          check("req_funct3", 32'(cif.cache_funct3), 32'(t.f3));
        end
      end
      if (cif.cache_done && cif.cache_req) begin
        last_done_cyc = cyc;
        if (cif.cache_we) n_stdone++;
      end
      if (cif.ld_done) begin
        n_lddone++;
        last_rdata = cif.ld_rdata;
        check("ld_rdata", cif.ld_rdata, rd_model(exp_ld_addr));
      end
      prev_req = cif.cache_req;
    end
  end
  task automatic wait_drained(input string name);
    int n = 0;
    @(negedge clk);
    while (!cif.drain_empty && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cif.drain_empty) to_fail(name);
    tick();
  endtask
  task automatic wait_ld_done(input string name);
    int n = 0;
    @(negedge clk);
    while (!cif.ld_done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cif.ld_done) to_fail(name);
    tick();
  endtask
  task automatic do_load(input logic [31:0] a, input logic [2:0] f3);
    exp_q.push_back(txn_t'{1'b0, a, 32'h0, f3});
    cif.ld_req = 1'b1;
    cif.ld_addr = a;
    cif.ld_funct3 = f3;
    wait_ld_done("ld_timeout");
    cif.ld_req = 1'b0;
  endtask
  task automatic push_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3, input bit track);
    int n = 0;
    while (!cif.st_ready && n < 100) begin
      tick();
      n++;
    end
    if (!cif.st_ready) to_fail("st_ready_timeout");
    if (track) exp_q.push_back(txn_t'{1'b1, a, d, f3});
    cif.st_valid = 1'b1;
    cif.st_addr = a;
    cif.st_data = d;
    cif.st_funct3 = f3;
    tick();
    cif.st_valid = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int stall_n, done_at, n, n0, s0, st_seen;
    vecs[0] = '{1'b1, 32'h0000_0200, 32'hDEAD_BEEF, 3'b010, 32'h0};
    vecs[1] = '{1'b1, 32'h0000_0204, 32'h1234_5678, 3'b001, 32'h0};
    vecs[2] = '{1'b0, 32'h0000_1234, 32'h0, 3'b100, 32'hC0DE_1234};
    vecs[3] = '{1'b1, 32'h0000_3008, 32'hA5A5_5A5A, 3'b000, 32'h0};
    vecs[4] = '{1'b0, 32'h0000_3008, 32'h0, 3'b010, 32'hC0DE_3008};
    vecs[5] = '{1'b0, 32'hFFFF_FFFC, 32'h0, 3'b101, 32'hC0DE_FFFC};
    cif.ld_req = 0; cif.ld_addr = 0; cif.ld_funct3 = 0; cif.flush = 0;
    cif.st_valid = 0; cif.st_addr = 0; cif.st_data = 0; cif.st_funct3 = 0;
    repeat (2) tick();
    @(negedge clk);
    check("rst_cache_req", 32'(cif.cache_req), 0);
    check("rst_cache_addr", cif.cache_addr, 0);
    check("rst_ld_done", 32'(cif.ld_done), 0);
    check("rst_st_ready", 32'(cif.st_ready), 1);
    check("rst_drain_empty", 32'(cif.drain_empty), 1);
    tick();
    reset = 1'b0;
    tick();
    exp_q.push_back(txn_t'{1'b0, 32'h100, 32'h0, 3'b010});
    cif.ld_req = 1'b1; cif.ld_addr = 32'h100; cif.ld_funct3 = 3'b010;
    stall_n = 0; done_at = -1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (cif.mem_stall) stall_n++;
      if (cif.ld_done) done_at = k;
      tick();
      if (done_at >= 0) cif.ld_req = 1'b0;
    end
    check("t1_done_cycle", done_at, 2);
    check("t1_stall_cycles", stall_n, 2);
    check("t1_rdata", last_rdata, 32'hC0DE_0100);
    s0 = n_stdone; st_seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].is_st) begin
        push_store(vecs[i].addr, vecs[i].data, vecs[i].f3, 1'b1);
        st_seen++;
      end else begin
        wait_drained("tbl_drain");
        check($sformatf("tbl%0d_stores_done", i), n_stdone - s0, st_seen);
        do_load(vecs[i].addr, vecs[i].f3);
        check($sformatf("tbl%0d_rdata", i), last_rdata, vecs[i].exp_rdata);
      end
    end
    n0 = n_lddone;
    for (int k = 0; k < 4; k++) exp_q.push_back(txn_t'{1'b0, 32'h400, 32'h0, 3'b010});
    exp_q.push_back(txn_t'{1'b1, 32'h300, 32'h3333_0000, 3'b010});
    exp_q.push_back(txn_t'{1'b0, 32'h400, 32'h0, 3'b010});
    cif.st_valid = 1'b1; cif.st_addr = 32'h300; cif.st_data = 32'h3333_0000; cif.st_funct3 = 3'b010;
    cif.flush = 1'b1; cif.ld_req = 1'b1; cif.ld_addr = 32'h400; cif.ld_funct3 = 3'b010;
    tick();
    cif.st_valid = 1'b0; cif.flush = 1'b0;
    n = 0;
    while (n_lddone - n0 < 5 && n < 300) begin
      tick();
      n++;
    end
    if (n_lddone - n0 < 5) to_fail("t3_loads");
    cif.ld_req = 1'b0;
    check("t3_load_count", n_lddone - n0, 5);
    wait_drained("t3_drain");
    exp_q.push_back(txn_t'{1'b1, 32'h500, 32'h5555_0000, 3'b010});
    push_store(32'h500, 32'h5555_0000, 3'b010, 1'b0);
    do_load(32'h502, 3'b001);
    check("t4_load_gap", last_gap, 2);
    wait_drained("t4_drain");
    lat = 6; s0 = n_stdone;
    exp_q.push_back(txn_t'{1'b0, 32'h900, 32'h0, 3'b010});
    exp_q.push_back(txn_t'{1'b1, 32'hA00, 32'hAAAA_0000, 3'b010});
    exp_q.push_back(txn_t'{1'b0, 32'h940, 32'h0, 3'b010});
    exp_q.push_back(txn_t'{1'b1, 32'hA04, 32'hAAAA_0004, 3'b010});
    cif.ld_req = 1'b1; cif.ld_addr = 32'h900; cif.ld_funct3 = 3'b010;
    tick();
    push_store(32'hA00, 32'hAAAA_0000, 3'b010, 1'b0);
    push_store(32'hA04, 32'hAAAA_0004, 3'b010, 1'b0);
    cif.st_valid = 1'b1; cif.st_addr = 32'hA08; cif.st_data = 32'hAAAA_0008;
    @(negedge clk);
    check("t5_full_st_ready", 32'(cif.st_ready), 0);
    tick();
    cif.st_valid = 1'b0;
    wait_ld_done("t5_ld1");
    cif.ld_addr = 32'h940;
    wait_ld_done("t5_ld2");
    cif.ld_req = 1'b0;
    wait_drained("t5_drain");
    check("t5_stores_done", n_stdone - s0, 2);
    check("t5_sb_empty", exp_q.size(), 0);
    lat = 5; n0 = n_lddone; s0 = n_stdone;
    exp_q.push_back(txn_t'{1'b0, 32'h600, 32'h0, 3'b010});
    exp_q.push_back(txn_t'{1'b1, 32'h700, 32'h7777_0000, 3'b010});
    cif.ld_req = 1'b1; cif.ld_addr = 32'h600; cif.ld_funct3 = 3'b010;
    tick();
    push_store(32'h700, 32'h7777_0000, 3'b010, 1'b0);
    cif.flush = 1'b1; cif.ld_req = 1'b0;
    tick();
    cif.flush = 1'b0;
    wait_drained("t6_drain");
    check("t6_no_ld_done", n_lddone - n0, 0);
    check("t6_store_drained", n_stdone - s0, 1);
    stray_done = 1'b1;
    @(negedge clk);
    check("idle_done_ld_done", 32'(cif.ld_done), 0);
    tick();
    stray_done = 1'b0;
    @(negedge clk);
    check("idle_done_req", 32'(cif.cache_req), 0);
    check("idle_done_drain_empty", 32'(cif.drain_empty), 1);
    tick();
    lat = 20;
    push_store(32'h800, 32'h8888_0000, 3'b110, 1'b1);
    n = 0;
    @(negedge clk);
    while (!(cif.cache_req && cif.cache_we) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!(cif.cache_req && cif.cache_we)) to_fail("t7_busy_st");
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("t7_cache_req", 32'(cif.cache_req), 0);
    check("t7_cache_we", 32'(cif.cache_we), 0);
    check("t7_cache_addr", cif.cache_addr, 0);
    check("t7_cache_wdata", cif.cache_wdata, 0);
    check("t7_cache_funct3", 32'(cif.cache_funct3), 0);
    check("t7_ld_done", 32'(cif.ld_done), 0);
    check("t7_st_ready", 32'(cif.st_ready), 1);
    check("t7_drain_empty", 32'(cif.drain_empty), 1);
    repeat (3) tick();
    check("sb_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/dcache_port_arbiter.md
# dcache_port_arbiter

Shares the single data-cache port between MEM-stage loads and committed stores drained from the store buffer. Committed stores are held in a small drain queue until the cache accepts them. Loads get priority, subject to a starvation bound and to a same-word ordering check against queued stores. The block sits between the store buffer / MEM stage and the data cache, and drives the MEM-stage stall.

## Interface
- DRAIN_Q_DEPTH, 2: committed-store queue entries (power of two, ≥2)
- STARVE_LIMIT, 4: consecutive load issues with a non-empty queue before a store is forced
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- ld_req  in  1  MEM-stage load request; held until ld_done or flush
- ld_addr  in  32  load address
- ld_funct3  in  3  load size/sign
- ld_done  out  1  one-cycle pulse: load complete, ld_rdata valid
- ld_rdata  out  32  pass-through of cache_rdata
- mem_stall  out  1  combinational: ld_req && !ld_done
- st_valid  in  1  committed store from store buffer
- st_addr  in  32  store address
- st_data  in  32  store data
- st_funct3  in  3  store size
- st_ready  out  1  queue not full (count < DRAIN_Q_DEPTH)
- flush  in  1  exception flush; drops the in-flight load, never queued stores
- cache_req  out  1  registered request, held until cache_done
- cache_we  out  1  1 = store, 0 = load
- cache_addr  out  32  registered address
- cache_wdata  out  32  registered write data (0 for loads)
- cache_funct3  out  3  registered size
- cache_done  in  1  one-cycle pulse ending the current request (hit or miss refill)
- cache_rdata  in  32  load data, valid with cache_done
- drain_empty  out  1  queue empty and no store in flight

## Operation
- Drain queue: circular FIFO, rd/wr pointers, count of width clog2(DRAIN_Q_DEPTH)+1. Enqueue when st_valid && st_ready. Dequeue on store issue.
- No full-bypass: when the queue is full, st_ready=0 even if a dequeue happens in the same cycle.
- FSM states: IDLE, BUSY_LD, BUSY_ST. Only one request is outstanding at a time.
- IDLE issue decision, evaluated every cycle:
  - force_st = (count == DRAIN_Q_DEPTH) || (starve_cnt >= STARVE_LIMIT) || conflict.
  - conflict = ld_req && any valid queue entry has addr[31:2] == ld_addr[31:2].
  - If count > 0 && (force_st || !ld_req): issue the head store, go to BUSY_ST, clear starve_cnt.
  - Else if ld_req && !flush: issue the load, go to BUSY_LD. Increment starve_cnt (saturating) if count > 0.
  - Else stay in IDLE.
- Issue action: latch cache_addr/wdata/funct3/we from the chosen source and set cache_req=1 on the next edge.
- BUSY_*: hold all cache_* outputs stable. On cache_done, drop cache_req, zero the cache_* registers, and return to IDLE. A new issue is possible one cycle later.
- BUSY_LD + cache_done: pulse ld_done the same cycle, unless the load was killed.
- flush:
  - In BUSY_LD, set a kill flag. The cache request continues to completion, but the matching cache_done produces no ld_done. The flag clears on that cache_done.
  - In IDLE, flush suppresses load issue that cycle.
  - The queue and BUSY_ST are unaffected.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance.
- Pointers wrap modulo DRAIN_Q_DEPTH.
- drain_empty = (count == 0) && state != BUSY_ST.

## Timing
- Reset values:
  - state IDLE; count, pointers, starve_cnt, kill 0.
  - cache_req/we/addr/wdata/funct3 0; ld_done 0; st_ready 1; drain_empty 1.
- reset overrides everything, including mid-BUSY. The cache is expected to be reset in the same cycle.
- Load latency, hit with cache_done one cycle after cache_req:
  - ld_req in IDLE at cycle n; cache_req=1 at n+1; cache_done at n+2; ld_done at n+2.
  - mem_stall is high for cycles n..n+1 and low at n+2.
- Store: enqueued at edge n; issued at n (if IDLE and selected); cache_req=1 at n+1.
- cache_done in IDLE is ignored.

## Test plan
- Reset, then ld_req addr 0x100; cache_done at the 2nd cycle -> ld_done at cycle 2, ld_rdata = cache_rdata, mem_stall high exactly 2 cycles.
- Enqueue 2 stores (0x200, 0x204) with ld_req idle -> two store writes in FIFO order, cache_we=1, wdata matching; drain_empty rises after the second cache_done.
- Queue holds store 0x300, continuous loads to 0x400 -> exactly 4 loads issue, then the store is forced (STARVE_LIMIT=4).
- Queued store to 0x500, then ld_req to 0x502 -> store issues first despite load priority; the load issues on the following IDLE cycle.
- Fill the queue (2 entries) -> st_ready=0; an st_valid pulse is not accepted; the store is issued before any pending load.
- flush during BUSY_LD (miss, cache_done 5 cycles later) -> no ld_done; queued stores still drain; reset mid-BUSY_ST -> all outputs return to reset values the next cycle.
